// File: rtl/rat_intr_ctrl.sv
// RAT CPU interrupt controller: synchronises and latches requests,
// then sequences the two-cycle entry (push PC, load vector 0x3FF).
module rat_intr_ctrl #(
  parameter  int N_SRC       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_DIN,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             BOUNDARY,
  output logic             CU_HOLD,
  output logic             PC_LD,
  output logic [1:0]       PC_MUX_SEL,
  output logic             SP_DECR,
  output logic             SCR_WE,
  output logic [1:0]       SCR_ADDR_SEL,
  output logic             SCR_DATA_SEL,
  output logic             FLG_SHAD_LD,
  output logic             I_FLAG,
  output logic [ID_W-1:0]  INTR_ID,
  output logic [N_SRC-1:0] PENDING
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PUSH = 2'b01,
    S_VEC  = 2'b10
  } state_t;

  state_t state;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] last_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] win_oh;
  logic [ID_W-1:0]  win_id;
  logic             take;

  // last_q holds the previous value of the final stage for edge detect
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      last_q <= '0;
    end else begin
      sync_q[0] <= IRQ;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
  assign elig = PENDING & mask;

  // isolate lowest set bit of the eligible vector
  assign win_oh = elig & (~elig + 1'b1);

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  assign take = (state == S_IDLE) & I_FLAG & (|elig) & BOUNDARY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask <= '0;
    end else if (MASK_WE) begin
      mask <= MASK_DIN;
    end
  end

  // a fresh edge on the winning source survives its own clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PENDING <= '0;
    end else begin
      PENDING <= (PENDING & ~(take ? win_oh : '0)) | rise;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      INTR_ID <= '0;
    end else if (take) begin
      INTR_ID <= win_id;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      I_FLAG <= 1'b0;
    end else if (state == S_PUSH) begin
      I_FLAG <= 1'b0;
    end else if (!CU_HOLD) begin
      if (I_CLR) begin
        I_FLAG <= 1'b0;
      end else if (I_SET) begin
        I_FLAG <= 1'b1;
      end
    end
  end

  // outputs are registered alongside the state they belong to
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      CU_HOLD      <= 1'b0;
      PC_LD        <= 1'b0;
      PC_MUX_SEL   <= 2'b00;
      SP_DECR      <= 1'b0;
      SCR_WE       <= 1'b0;
      SCR_ADDR_SEL <= 2'b00;
      SCR_DATA_SEL <= 1'b0;
      FLG_SHAD_LD  <= 1'b0;
    end else begin
      CU_HOLD      <= 1'b0;
      PC_LD        <= 1'b0;
      PC_MUX_SEL   <= 2'b00;
      SP_DECR      <= 1'b0;
      SCR_WE       <= 1'b0;
      SCR_ADDR_SEL <= 2'b00;
      SCR_DATA_SEL <= 1'b0;
      FLG_SHAD_LD  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            state        <= S_PUSH;
            CU_HOLD      <= 1'b1;
            SCR_WE       <= 1'b1;
            SCR_ADDR_SEL <= 2'b11;
            SCR_DATA_SEL <= 1'b1;
            SP_DECR      <= 1'b1;
            FLG_SHAD_LD  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PUSH: begin
          state      <= S_VEC;
          CU_HOLD    <= 1'b1;
          PC_LD      <= 1'b1;
          PC_MUX_SEL <= 2'b10;
        end
        S_VEC: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed bench for rat_intr_ctrl with a cycle model of the
// request/entry rules checked every cycle plus literal pins.
module tb_rat_intr_ctrl;

  localparam int N    = 4;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         RESET = 1'b0;
  logic [N-1:0] IRQ = '0;
  logic         MASK_WE = 1'b0;
  logic [N-1:0] MASK_DIN = '0;
  logic         I_SET = 1'b0;
  logic         I_CLR = 1'b0;
  logic         BOUNDARY = 1'b0;
  logic         CU_HOLD, PC_LD, SP_DECR, SCR_WE, SCR_DATA_SEL;
  logic         FLG_SHAD_LD, I_FLAG;
  logic [1:0]   PC_MUX_SEL, SCR_ADDR_SEL;
  logic [1:0]   INTR_ID;
  logic [N-1:0] PENDING;

  int checks = 0;
  int failures = 0;

  rat_intr_ctrl #(.N_SRC(N), .SYNC_STAGES(SYNC)) dut (
    .CLK(clk), .RESET(RESET), .IRQ(IRQ),
    .MASK_WE(MASK_WE), .MASK_DIN(MASK_DIN),
    .I_SET(I_SET), .I_CLR(I_CLR), .BOUNDARY(BOUNDARY),
    .CU_HOLD(CU_HOLD), .PC_LD(PC_LD), .PC_MUX_SEL(PC_MUX_SEL),
    .SP_DECR(SP_DECR), .SCR_WE(SCR_WE),
    .SCR_ADDR_SEL(SCR_ADDR_SEL), .SCR_DATA_SEL(SCR_DATA_SEL),
    .FLG_SHAD_LD(FLG_SHAD_LD), .I_FLAG(I_FLAG),
    .INTR_ID(INTR_ID), .PENDING(PENDING)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // model: IRQ sample history, pend/mask/I/id, entry phase
  logic [N-1:0] h [0:SYNC];
  logic [N-1:0] m_pend = '0, m_mask = '0;
  logic         m_i = 1'b0;
  int           m_id = 0;
  int           m_phase = 0;
  bit           m_valid = 0;

  always @(posedge clk) begin
    logic [N-1:0] rs, el;
    int  w;
    bit  tk;
    if (RESET) begin
      for (int k = 0; k <= SYNC; k++) h[k] = '0;
      m_pend = '0; m_mask = '0; m_i = 0;
      m_id = 0; m_phase = 0; m_valid = 1;
    end else begin
      rs = h[SYNC-1] & ~h[SYNC];
      for (int k = SYNC; k > 0; k--) h[k] = h[k-1];
      h[0] = IRQ;
      el = m_pend & m_mask;
      w = -1;
      for (int i = 0; i < N; i++)
        if (el[i] && w < 0) w = i;
      tk = (m_phase == 0) && m_i && (w >= 0) && BOUNDARY;
      if (m_phase == 1) m_i = 0;
      else if (m_phase == 0) begin
        if (I_CLR) m_i = 0;
        else if (I_SET) m_i = 1;
      end
      if (tk) begin
        m_pend[w] = 1'b0;
        m_id = w;
      end
      m_pend = m_pend | rs;
      if (MASK_WE) m_mask = MASK_DIN;
      if (tk) m_phase = 1;
      else if (m_phase == 1) m_phase = 2;
      else m_phase = 0;
    end
  end

  bit pc_ld_seen = 0;

  always @(negedge clk) begin
    logic [16:0] got, exp;
    bit p, v;
    if (m_valid) begin
      p = (m_phase == 1);
      v = (m_phase == 2);
      exp = {p | v, v, v ? 2'b10 : 2'b00, p, p,
             p ? 2'b11 : 2'b00, p, p, m_i, 2'(m_id), m_pend};
      got = {CU_HOLD, PC_LD, PC_MUX_SEL, SP_DECR, SCR_WE,
             SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SHAD_LD, I_FLAG,
             INTR_ID, PENDING};
      chk("model", int'(got), int'(exp));
      if (PC_LD === 1'b1) pc_ld_seen = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_set();
    I_SET = 1; tick(1); I_SET = 0;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    MASK_WE = 1; MASK_DIN = m; tick(1); MASK_WE = 0;
  endtask

  initial begin
    tick(1);
    // 1: reset
    RESET = 1; IRQ = '0; tick(1); RESET = 0;
    chk("rst_pend", PENDING, 0);
    chk("rst_i", I_FLAG, 0);
    chk("rst_hold", CU_HOLD, 0);
    chk("rst_id", INTR_ID, 0);
    chk("rst_pcld", PC_LD, 0);

    // 2: basic entry of source 2
    set_mask(4'b1111);
    pulse_set();
    chk("iset", I_FLAG, 1);
    IRQ[2] = 1; tick(2);
    chk("lat2", PENDING, 0);
    tick(1);
    chk("lat3", PENDING, 4'b0100);
    BOUNDARY = 1; tick(1); BOUNDARY = 0;
    chk("push_hold", CU_HOLD, 1);
    chk("push_we", SCR_WE, 1);
    chk("push_adr", SCR_ADDR_SEL, 2'b11);
    chk("push_spd", SP_DECR, 1);
    chk("push_pcld", PC_LD, 0);
    tick(1);
    chk("vec_pcld", PC_LD, 1);
    chk("vec_sel", PC_MUX_SEL, 2'b10);
    chk("vec_id", INTR_ID, 2);
    chk("vec_pend", PENDING, 0);
    chk("vec_i", I_FLAG, 0);
    tick(1);
    chk("rel_hold", CU_HOLD, 0);

    // 3: lowest of 1010 wins
    IRQ[1] = 1; IRQ[3] = 1;
    pulse_set();
    tick(3);
    chk("p1010", PENDING, 4'b1010);
    BOUNDARY = 1; tick(1); BOUNDARY = 0;
    tick(2);
    chk("id1", INTR_ID, 1);
    chk("p1000", PENDING, 4'b1000);

    // 4: masked source stays pending
    set_mask(4'b0000);
    IRQ = '0; tick(3);
    IRQ[0] = 1;
    pulse_set();
    tick(3);
    BOUNDARY = 1; tick(5); BOUNDARY = 0;
    chk("mask_hold", CU_HOLD, 0);
    chk("mask_pend", PENDING, 4'b1001);
    set_mask(4'b0001);
    BOUNDARY = 1; tick(1); BOUNDARY = 0;
    chk("m_push", CU_HOLD, 1);
    tick(2);
    chk("id0", INTR_ID, 0);
    chk("p_after0", PENDING, 4'b1000);

    // 5: I_CLR beats I_SET; I_SET ignored in entry
    pulse_set();
    I_SET = 1; I_CLR = 1; tick(1); I_CLR = 0; I_SET = 0;
    chk("clr_wins", I_FLAG, 0);
    pulse_set();
    set_mask(4'b1111);
    I_SET = 1; BOUNDARY = 1; tick(1); BOUNDARY = 0;
    tick(2); I_SET = 0;
    chk("iset_hold", I_FLAG, 0);
    chk("id3", INTR_ID, 3);

    // 6: reset mid-entry, then set-beats-clear
    IRQ = '0; tick(3);
    IRQ[1] = 1;
    pulse_set();
    tick(3);
    BOUNDARY = 1; tick(1); BOUNDARY = 0;
    chk("r_push", CU_HOLD, 1);
    pc_ld_seen = 0;
    RESET = 1; IRQ = '0; tick(1); RESET = 0;
    chk("r_hold", CU_HOLD, 0);
    chk("r_pend", PENDING, 0);
    tick(3);
    chk("r_nopcld", int'(pc_ld_seen), 0);
    set_mask(4'b1111);
    pulse_set();
    IRQ[1] = 1; tick(3);
    chk("s_pend", PENDING, 4'b0010);
    IRQ[1] = 0; tick(3);
    IRQ[1] = 1; tick(2);
    BOUNDARY = 1; tick(1); BOUNDARY = 0;
    tick(2);
    chk("s_id", INTR_ID, 1);
    chk("s_kept", PENDING, 4'b0010);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
